// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher: boolean aliases,
// datapath width, fetch FSM state encoding and the sequential-PC helper.
package instruction_fetcher_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int   XLEN  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_e;

    // Sequential fetch only; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetcher-facing bus: push port into the instruction queue, word request port
// to the memory controller and the ROB redirect inputs.
interface instruction_fetcher_if;
    import instruction_fetcher_pkg::*;

    // Queue push: an instruction transfers on every edge where ins_ready_out=1;
    // the fetcher never raises it while queue_full_in=1. Memory: mem_req_out is a
    // level held (with a stable mem_addr_out) until the single-cycle mem_done_in
    // pulse that carries mem_data_in. jump_flag_in is a one-cycle redirect pulse.
    logic            queue_full_in;
    logic            ins_ready_out;
    logic [XLEN-1:0] ins_out;
    logic [XLEN-1:0] ins_pc_out;
    logic            mem_req_out;
    logic [XLEN-1:0] mem_addr_out;
    logic            mem_done_in;
    logic [XLEN-1:0] mem_data_in;
    logic            jump_flag_in;
    logic [XLEN-1:0] jump_pc_in;

    modport master (
        input  queue_full_in, mem_done_in, mem_data_in, jump_flag_in, jump_pc_in,
        output ins_ready_out, ins_out, ins_pc_out, mem_req_out, mem_addr_out
    );

    modport slave (
        output queue_full_in, mem_done_in, mem_data_in, jump_flag_in, jump_pc_in,
        input  ins_ready_out, ins_out, ins_pc_out, mem_req_out, mem_addr_out
    );

endinterface

// File: rtl/instruction_fetcher_icache.sv
// Direct-mapped one-word-per-line icache: combinational lookup, one synchronous
// fill port, valid bits cleared by the asynchronous reset.
module instruction_fetcher_icache
    import instruction_fetcher_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = XLEN - IDX_W - 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [XLEN-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_data
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [XLEN-1:0]    data_q [ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = TRUE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) valid_q <= '0;
        else         valid_q <= valid_d;
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/instruction_fetcher.sv
// Sequential instruction fetcher: icache lookup at the fetch PC, single-word
// miss requests to memory, one-entry hold buffer feeding the instruction queue.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int              ICACHE_IDX_W = 6,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    instruction_fetcher_if.master bus,
    output fetch_state_e          state_dbg_out
);
    localparam int TAG_W = XLEN - ICACHE_IDX_W - 2;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;

    logic            ins_ready;
    logic            hold_accept;
    logic            cache_hit;
    logic [XLEN-1:0] cache_data;
    logic            cache_we;

    // Fills always target the outstanding request address, which also covers
    // the discarded word after a redirect.
    instruction_fetcher_icache #(.IDX_W(ICACHE_IDX_W), .TAG_W(TAG_W)) u_icache (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (pc_q[ICACHE_IDX_W+1:2]),
        .rd_tag  (pc_q[XLEN-1:ICACHE_IDX_W+2]),
        .rd_hit  (cache_hit),
        .rd_data (cache_data),
        .wr_en   (cache_we),
        .wr_idx  (mem_addr_q[ICACHE_IDX_W+1:2]),
        .wr_tag  (mem_addr_q[XLEN-1:ICACHE_IDX_W+2]),
        .wr_data (bus.mem_data_in)
    );

    assign ins_ready   = hold_valid_q & ~bus.queue_full_in & rdy_in & ~bus.jump_flag_in;
    assign hold_accept = ~hold_valid_q | ins_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cache_we     = FALSE;
        if (rdy_in) begin
            if (ins_ready) hold_valid_d = FALSE;
            unique case (state_q)
                IDLE: begin
                    if (bus.jump_flag_in) begin
                        pc_d         = bus.jump_pc_in;
                        hold_valid_d = FALSE;
                    end else if (hold_accept && cache_hit) begin
                        hold_valid_d = TRUE;
                        hold_instr_d = cache_data;
                        hold_pc_d    = pc_q;
                        pc_d         = next_pc(pc_q);
                    end else if (hold_accept) begin
                        mem_req_d  = TRUE;
                        mem_addr_d = pc_q;
                        state_d    = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_done_in) begin
                        cache_we  = TRUE;
                        mem_req_d = FALSE;
                        state_d   = IDLE;
                        if (bus.jump_flag_in) begin
                            pc_d         = bus.jump_pc_in;
                            hold_valid_d = FALSE;
                        end else begin
                            hold_valid_d = TRUE;
                            hold_instr_d = bus.mem_data_in;
                            hold_pc_d    = pc_q;
                            pc_d         = next_pc(pc_q);
                        end
                    end else if (bus.jump_flag_in) begin
                        // The controller cannot cancel; keep requesting and drop the word.
                        pc_d         = bus.jump_pc_in;
                        hold_valid_d = FALSE;
                        state_d      = DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.jump_flag_in) begin
                        pc_d         = bus.jump_pc_in;
                        hold_valid_d = FALSE;
                    end
                    if (bus.mem_done_in) begin
                        cache_we  = TRUE;
                        mem_req_d = FALSE;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            hold_valid_q <= FALSE;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            mem_req_q    <= FALSE;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign bus.ins_ready_out = ins_ready;
    assign bus.ins_out       = hold_instr_q;
    assign bus.ins_pc_out    = hold_pc_q;
    assign bus.mem_req_out   = mem_req_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign state_dbg_out     = state_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: memory responder, queue/redirect driver and a
// model of the expected push stream and cache contents.
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    logic         clk;
    logic         rst_in;
    logic         rdy_in;
    fetch_state_e state_dbg;

    instruction_fetcher_if bus();

    instruction_fetcher #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .bus           (bus.master),
        .state_dbg_out (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          push_cnt = 0;
    int          req_cnt = 0;
    int          mem_cnt = 0;
    int          lat = 3;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_req_addr = '0;
    logic [31:0] last_push_pc = '0;
    logic [31:0] exp_q[$];
    logic        mc_valid [64];
    logic [31:0] mc_addr  [64];

    logic        k_full = 1'b0;
    logic        k_rdy  = 1'b1;
    logic        k_jmp  = 1'b0;
    logic [31:0] k_jpc  = '0;

    // Memory image: every address holds a distinct, non-zero word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return mc_valid[a[7:2]] && (mc_addr[a[7:2]] == a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend = 1'b0;
        for (int i = 0; i < 64; i++) mc_valid[i] = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        logic [31:0] pc_now;
        @(negedge clk);
        cyc++;
        rdy_in           = k_rdy;
        bus.queue_full_in = k_full;
        bus.jump_flag_in = k_jmp & k_rdy;
        bus.jump_pc_in   = k_jpc;
        bus.mem_done_in  = 1'b0;
        bus.mem_data_in  = $urandom;
        if (pend && k_rdy) begin
            if (mem_cnt <= 1) begin
                bus.mem_done_in = 1'b1;
                bus.mem_data_in = mem_word(pend_addr);
            end else begin
                mem_cnt--;
            end
        end
        #1;
        check("push_gate", 32'(bus.ins_ready_out & (k_full | ~k_rdy | bus.jump_flag_in)), 32'd0);
        check("push_vs_req", 32'(bus.ins_ready_out & bus.mem_req_out &
                                 (bus.mem_addr_out == bus.ins_pc_out)), 32'd0);
        if (bus.ins_ready_out) begin
            pc_now = exp_q.pop_front();
            check("push_pc", bus.ins_pc_out, pc_now);
            check("push_ins", bus.ins_out, mem_word(pc_now));
            exp_q.push_back(pc_now + 32'd4);
            last_push_pc = bus.ins_pc_out;
            push_cnt++;
        end
        if (pend) begin
            check("req_held", 32'(bus.mem_req_out), 32'd1);
            check("req_addr", bus.mem_addr_out, pend_addr);
            if (bus.mem_done_in) begin
                pend = 1'b0;
                mc_valid[pend_addr[7:2]] = 1'b1;
                mc_addr[pend_addr[7:2]]  = pend_addr;
            end
        end else if (bus.mem_req_out) begin
            check("req_miss", 32'(model_hit(bus.mem_addr_out)), 32'd0);
            pend          = 1'b1;
            pend_addr     = bus.mem_addr_out;
            last_req_addr = bus.mem_addr_out;
            mem_cnt       = lat;
            req_cnt++;
        end
        if (bus.jump_flag_in) begin
            exp_q.delete();
            exp_q.push_back(k_jpc);
        end
        k_jmp = 1'b0;
    endtask

    task automatic run_until_pushes(input int n, input string tag);
        int target;
        int guard;
        target = push_cnt + n;
        guard  = 0;
        while (push_cnt < target && guard < 500) begin
            step();
            guard++;
        end
        check(tag, 32'(push_cnt), 32'(target));
    endtask

    task automatic wait_req(input string tag);
        int r;
        int guard;
        r     = req_cnt;
        guard = 0;
        while (req_cnt == r && guard < 200) begin
            step();
            guard++;
        end
        check(tag, 32'(req_cnt - r), 32'd1);
    endtask

    // Redirect, then check the first push is the target and how many misses it took.
    task automatic jump_expect(input logic [31:0] target, input int exp_reqs, input string tag);
        int r;
        k_jmp = 1'b1;
        k_jpc = target;
        step();
        r = req_cnt;
        run_until_pushes(1, {tag, "_push"});
        check({tag, "_pc"}, last_push_pc, target);
        check({tag, "_reqs"}, 32'(req_cnt - r), 32'(exp_reqs));
        if (exp_reqs != 0) check({tag, "_req_addr"}, last_req_addr, target);
    endtask

    task automatic reset_dut();
        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        bus.queue_full_in = 1'b0;
        bus.mem_done_in   = 1'b0;
        bus.mem_data_in   = '0;
        bus.jump_flag_in  = 1'b0;
        bus.jump_pc_in    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ins_ready", 32'(bus.ins_ready_out), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
        check("rst_mem_addr", bus.mem_addr_out, 32'd0);
        check("rst_ins", bus.ins_out, 32'd0);
        check("rst_ins_pc", bus.ins_pc_out, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r0;
        int c0;
        int streak;
        int guard;

        reset_dut();

        // Cold start, latency 3: pcs 0..C, one miss each.
        lat = 3;
        r0  = req_cnt;
        run_until_pushes(4, "cold_pushes");
        check("cold_reqs", 32'(req_cnt - r0), 32'd4);

        // Loop back to 0: four hits on consecutive cycles.
        k_jmp = 1'b1;
        k_jpc = 32'h0;
        step();
        run_until_pushes(1, "loop_first");
        c0 = cyc;
        r0 = req_cnt;
        run_until_pushes(3, "loop_rest");
        check("loop_consecutive", 32'(cyc - c0), 32'd3);
        check("loop_no_req", 32'(req_cnt - r0), 32'd0);

        // Queue full with the hold buffer occupied.
        k_full = 1'b1;
        streak = 0;
        guard  = 0;
        while (streak < 2 && guard < 200) begin
            step();
            guard++;
            if (state_dbg == IDLE && !pend) streak++;
            else streak = 0;
        end
        check("full_settle", 32'(streak), 32'd2);
        r0 = req_cnt;
        for (int i = 0; i < 10; i++) begin
            step();
            check("full_hold_pc", bus.ins_pc_out, exp_q[0]);
        end
        check("full_no_req", 32'(req_cnt - r0), 32'd0);
        k_full = 1'b0;
        run_until_pushes(6, "full_resume");

        // Redirect two cycles into a miss for 0x20.
        reset_dut();
        lat   = 6;
        k_jmp = 1'b1;
        k_jpc = 32'h20;
        step();
        wait_req("redir_req0");
        check("redir_req0_addr", last_req_addr, 32'h20);
        step();
        k_jmp = 1'b1;
        k_jpc = 32'h100;
        step();
        wait_req("redir_req1");
        check("redir_req1_addr", last_req_addr, 32'h100);
        run_until_pushes(1, "redir_push");
        check("redir_push_pc", last_push_pc, 32'h100);
        jump_expect(32'h20, 0, "redir_cached");

        // Aliasing at index 0.
        lat = 2;
        jump_expect(32'h0,   1, "alias_a");
        jump_expect(32'h100, 1, "alias_b");
        jump_expect(32'h0,   1, "alias_c");

        // Pause during a miss, then reset mid-miss.
        lat   = 8;
        k_jmp = 1'b1;
        k_jpc = 32'h400;
        step();
        wait_req("pause_req");
        check("pause_req_addr", last_req_addr, 32'h400);
        k_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pause_mem_req", 32'(bus.mem_req_out), 32'd1);
            check("pause_mem_addr", bus.mem_addr_out, 32'h400);
            check("pause_ready", 32'(bus.ins_ready_out), 32'd0);
            check("pause_state", 32'(state_dbg), 32'(WAIT_MEM));
        end
        k_rdy = 1'b1;
        step();
        @(posedge clk);
        #2;
        rst_in = 1'b0;
        #1;
        check("midrst_mem_req", 32'(bus.mem_req_out), 32'd0);
        check("midrst_ready", 32'(bus.ins_ready_out), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        model_reset();
        bus.mem_done_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        lat    = 3;
        r0     = req_cnt;
        run_until_pushes(2, "restart_pushes");
        check("restart_reqs", 32'(req_cnt - r0), 32'd2);

        // Randomized traffic over a small address window to force aliasing.
        for (int i = 0; i < 2500; i++) begin
            k_full = ($urandom_range(0, 3) == 0);
            k_rdy  = ($urandom_range(0, 9) != 0);
            k_jmp  = ($urandom_range(0, 39) == 0);
            k_jpc  = 32'($urandom_range(0, 255)) << 2;
            lat    = $urandom_range(1, 5);
            step();
        end
        k_full = 1'b0;
        k_rdy  = 1'b1;
        k_jmp  = 1'b0;
        run_until_pushes(4, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Front-end fetch unit that produces the instruction stream pushed into the instruction queue (the producer end of instruction_ready/instruction/pc). It holds the architectural fetch PC, looks it up in a small direct-mapped icache, and requests a word from the memory controller on a miss. It redirects on a ROB jump/mispredict and never pushes while the queue reports full. Fetch is strictly sequential (pc+4), with no branch prediction.

Parameters:
ICACHE_IDX_W, 6, log2 of icache word entries (64 one-word lines)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low (0 = reset)
rdy_in  input  1  global ready; low = pause, all state frozen
queue_full_in  input  1  instruction queue is_full
ins_ready_out  output  1  push strobe to queue; one instruction per high cycle
ins_out  output  32  instruction word, valid when ins_ready_out=1
ins_pc_out  output  32  PC of ins_out
mem_req_out  output  1  word fetch request to memory controller, level held until done
mem_addr_out  output  32  word-aligned fetch address
mem_done_in  input  1  one-cycle pulse: mem_data_in valid
mem_data_in  input  32  fetched word
jump_flag_in  input  1  ROB redirect, one-cycle pulse
jump_pc_in  input  32  redirect target

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC; all icache valid bits 0; hold buffer empty; state IDLE; mem_req_out=0; mem_addr_out=0; ins_out/ins_pc_out=0. ins_ready_out is therefore 0.
- Hold buffer: one entry {instr, pc, valid}.
  - ins_ready_out = hold.valid & ~queue_full_in & rdy_in & ~jump_flag_in (combinational gate, so no push is ever issued into a full queue).
  - The entry is consumed at the edge where ins_ready_out=1.
  - A new entry may be loaded in the same cycle the old one is consumed.
- Hold can accept = ~hold.valid | ins_ready_out.
- State machine, rdy_in=1:
  - IDLE:
    - If jump_flag_in=1: pc<=jump_pc_in, hold.valid<=0; stay IDLE.
    - Else if hold can accept and icache hit at pc: load hold with {cache word, pc}; pc<=pc+4. Hit throughput is 1 instruction/cycle.
    - Else if hold can accept and miss: mem_req_out<=1, mem_addr_out<=pc; go WAIT_MEM.
  - WAIT_MEM:
    - On mem_done_in: write icache[pc idx] = {tag, mem_data_in, valid}; load hold (hold is guaranteed to accept, because it was empty or drained in IDLE). Then pc<=pc+4, mem_req_out<=0, go IDLE.
    - If jump_flag_in arrives and mem_done_in is not in the same cycle: pc<=jump_pc_in, hold.valid<=0, go DISCARD. mem_req_out stays high, because the controller cannot cancel.
    - If jump_flag_in and mem_done_in arrive together: still write the icache; do not load hold; pc<=jump_pc_in; mem_req_out<=0; go IDLE.
  - DISCARD: on mem_done_in, write the icache with the old address's data, drop the word, mem_req_out<=0, go IDLE.
- Icache addressing:
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - hit = valid[index] & (tag == stored tag).
- pc+4 wraps modulo 2^32. pc[1:0] is assumed 0; jump targets are word-aligned by the ROB.
- rdy_in=0: no state, pc, cache or hold update; ins_ready_out=0; mem_req_out/mem_addr_out hold their values.
- jump_flag_in has priority over every fetch action in the same cycle. The instruction queue's own flush is handled outside this block.
- Reset asserted mid-miss: everything returns to reset values immediately, and mem_req_out drops asynchronously.

Decomposition:
- Shared defines header: TRUE/FALSE and the fetcher state encodings IDLE/WAIT_MEM/DISCARD.
- One sub-module: icache, a direct-mapped valid/tag/data array.
  - Combinational read port: hit, data.
  - One synchronous write port.
  - Async active-low clear of the valid bits.

Test Plan:
- Cold start, queue never full, memory latency 3: the first four pushes carry pc 0x0, 0x4, 0x8, 0xC, each with the word returned by memory. mem_req_out rises once per instruction, and ins_ready_out is never high while mem_req_out is high for the same pc.
- Loop re-fetch: after the cold fetch of 0x0–0xC, pulse jump_flag_in with jump_pc_in=0x0. The next pushes are 0x0, 0x4, 0x8, 0xC on consecutive cycles, with mem_req_out held 0 (all hits).
- Queue full: hold queue_full_in=1 for 10 cycles with the hold valid. ins_ready_out stays 0, pc is unchanged, and no extra mem_req_out occurs. After release, the pushes resume at the held pc with no instruction lost or duplicated.
- Redirect during miss: jump to 0x100 two cycles after a miss request for 0x20. Memory then returns the word for 0x20: it is not pushed but is cached. The next mem_addr_out is 0x100, and the next push has pc 0x100.
- Aliasing: fetch 0x0, then jump to 0x100 (same index, ICACHE_IDX_W=6). 0x100 misses and replaces the entry; a jump back to 0x0 misses again.
- Pause and reset: hold rdy_in=0 for 5 cycles during WAIT_MEM and all outputs are frozen. Then assert rst_in=0 mid-miss: mem_req_out=0 and ins_ready_out=0 immediately, and after release the fetch restarts at RESET_PC with cache misses.
